peripheral_bus: RTL and testbench
=================================

// Module: peripheral_bus
// PURPOSE
//  Memory-mapped peripheral block downstream of the single-cycle CPU's load/store path.
//  Decodes ALU address, MemRead, MemWrite and Write_data in parallel with DataMemory; the CPU muxes on addr[30].
//  Holds a reloadable timer with interrupt, LED, switch and 7-seg registers, and a systick counter.
//  irq drives the CPU's exception logic (PC <= 0x80000008 when taken).
// PARAMETERS
//  BASE_ADDR  32'h40000000  base of the 32-byte register window (word aligned)
//  LED_W      8             LED register width
//  SW_W       8             switch input width
// PORTS
//  clk         in   1      system clock, all state on posedge
//  reset       in   1      synchronous, active-high
//  MemRead     in   1      CPU load strobe
//  MemWrite    in   1      CPU store strobe, committed at posedge clk
//  Address     in   32     byte address from CPU ALU
//  Write_data  in   32     store data (CPU rt)
//  Read_data   out  32     load data, combinational
//  irq         out  1      timer interrupt request, level
//  led         out  LED_W  LED register
//  switch      in   SW_W   asynchronous board switches
//  digi        out  12     7-seg: [11:8] anode enables, [7:0] segments
// BEHAVIOUR
//  Map, offset from BASE_ADDR: 0x00 TH (rw), 0x04 TL (rw), 0x08 TCON (rw, bits[2:0]),
//   0x0C LED (rw), 0x10 SWITCH (ro), 0x14 DIGI (rw), 0x18 SYSTICK (ro).
//  Hit = Address[31:5]==BASE_ADDR[31:5] && Address[1:0]==0 && offset<=0x18; else no effect.
//  Reset: TH=TL=0, TCON=0, led=0, digi=0, systick=0, switch sync flops=0; irq=0.
//  Read_data = register value when MemRead && hit; otherwise 32'h0. Unused bits read 0.
//  Writes to ro offsets, misses, and misaligned addresses are ignored.
//  TCON: [0] enable, [1] irq_en, [2] irq_status. irq = TCON[1] & TCON[2].
//  Timer, each cycle with TCON[0]=1: TL==32'hFFFFFFFF -> TL<=TH, and TCON[2]<=1 if TCON[1];
//   otherwise TL<=TL+1 (mod 2^32).
//  Enable=0: TL and TCON[2] hold.
//  Software clears irq by writing TCON with bit2=0; writing bit2=1 sets it (test aid).
//  Same-cycle conflicts:
//   - CPU write to TL beats increment/reload.
//   - Overflow-set of TCON[2] beats a software clear in the same cycle; no lost interrupt.
//   - Write to TH in the reload cycle: reload uses the old TH.
//  SYSTICK: free-running 32-bit, +1 every cycle, wraps to 0, not writable.
//  SWITCH: 2-flop synchroniser, so reads lag the pin by 2 cycles.
//  LED/DIGI: register outputs, update on the posedge after the store.
//  Reset asserted mid-count clears all state at that edge; no partial reload.
// STRUCTURE
//  Shared package periph_pkg: offset constants (OFF_TH..OFF_SYSTICK), TCON bit indices.
//  One sub-module, timer_core: TH/TL/TCON, reload, irq.
//  Inputs: wr_th, wr_tl, wr_tcon, wdata. Outputs: th, tl, tcon.
//  Top level holds decode, read mux, LED/DIGI/SYSTICK registers and the switch synchroniser.
// TESTING
//  1 Reset, then read every offset -> all 0 except SWITCH (=pin value after 2 cycles).
//  2 TH=0xFFFFFFFD, TL=0xFFFFFFFE, TCON=3 -> TL is 0xFFFFFFFF at +1; at +2 TL=0xFFFFFFFD, irq=1;
//    at +3 TL=0xFFFFFFFE.
//  3 irq=1, store TCON=3 in the same cycle as another overflow -> irq stays 1.
//    Store TCON=3 on a quiet cycle -> irq=0 next cycle.
//  4 Store 0xA5 to LED, 0xF3F to DIGI -> led=0xA5, digi=0xF3F next edge.
//    Store to 0x40000010 -> no change.
//  5 Load 0x40000002 or 0x40000020 -> Read_data=0; store there -> no register changes.
//  6 Assert reset for 1 cycle while timer runs with irq=1 -> irq=0, TL=0, systick restarts at 0.

Source files
------------

// File: rtl/periph_pkg.sv
// periph_pkg: register offsets and TCON bit positions shared by the peripheral bus.
package periph_pkg;
  localparam logic [4:0] OFF_TH      = 5'h00;
  localparam logic [4:0] OFF_TL      = 5'h04;
  localparam logic [4:0] OFF_TCON    = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_SWITCH  = 5'h10;
  localparam logic [4:0] OFF_DIGI    = 5'h14;
  localparam logic [4:0] OFF_SYSTICK = 5'h18;
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;
endpackage

// File: rtl/timer_core.sv
// timer_core: reloadable up-counting timer with sticky interrupt status.
module timer_core
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon
);
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;
  always_comb begin
    ovf    = tcon_q[TCON_EN] && tl_q == 32'hFFFF_FFFF;
    th_d   = wr_th ? wdata : th_q;
    tl_d   = wr_tl ? wdata : !tcon_q[TCON_EN] ? tl_q : ovf ? th_q : tl_q + 32'd1;
    tcon_d = wr_tcon ? wdata[2:0] : tcon_q;
    // overflow wins over a same-cycle software clear so no interrupt is lost
    tcon_d[TCON_IS] = tcon_d[TCON_IS] | (ovf & tcon_q[TCON_IE]);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end
  assign th   = th_q;
  assign tl   = tl_q;
  assign tcon = tcon_q;
endmodule

// File: rtl/peripheral_bus.sv
// peripheral_bus: memory-mapped timer, LED, switch, 7-seg and systick registers for the CPU.
module peripheral_bus
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      Address,
  input  logic [31:0]      Write_data,
  output logic [31:0]      Read_data,
  output logic             irq,
  output logic [LED_W-1:0] led,
  input  logic [SW_W-1:0]  switch,
  output logic [11:0]      digi
);
  logic [4:0]       off;
  logic             hit, wr;
  logic [31:0]      th, tl, rd;
  logic [2:0]       tcon;
  logic [LED_W-1:0] led_q, led_d;
  logic [11:0]      digi_q, digi_d;
  logic [31:0]      systick_q, systick_d;
  logic [SW_W-1:0]  sw1_q, sw1_d, sw2_q, sw2_d;
  assign off = Address[4:0];
  assign hit = Address[31:5] == BASE_ADDR[31:5] && Address[1:0] == 2'b00 && off <= OFF_SYSTICK;
  assign wr  = MemWrite && hit;
  timer_core u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr && off == OFF_TH),
    .wr_tl   (wr && off == OFF_TL),
    .wr_tcon (wr && off == OFF_TCON),
    .wdata   (Write_data),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );
  always_comb begin
    led_d     = (wr && off == OFF_LED) ? Write_data[LED_W-1:0] : led_q;
    digi_d    = (wr && off == OFF_DIGI) ? Write_data[11:0] : digi_q;
    systick_d = systick_q + 32'd1;
    sw1_d     = switch;
    sw2_d     = sw1_q;
    rd        = '0;
    case (off)
      OFF_TH:      rd = th;
      OFF_TL:      rd = tl;
      OFF_TCON:    rd = {29'd0, tcon};
      OFF_LED:     rd = 32'(led_q);
      OFF_SWITCH:  rd = 32'(sw2_q);
      OFF_DIGI:    rd = {20'd0, digi_q};
      OFF_SYSTICK: rd = systick_q;
      default:     rd = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      systick_q <= '0;
      sw1_q     <= '0;
      sw2_q     <= '0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      systick_q <= systick_d;
      sw1_q     <= sw1_d;
      sw2_q     <= sw2_d;
    end
  end
  assign Read_data = (MemRead && hit) ? rd : 32'h0;
  assign irq       = tcon[TCON_IE] & tcon[TCON_IS];
  assign led       = led_q;
  assign digi      = digi_q;
endmodule

// File: tb/tb_peripheral_bus.sv
// tb_peripheral_bus: register-level model plus directed scenarios for peripheral_bus.
module tb_peripheral_bus;
  localparam logic [31:0] BASE = 32'h4000_0000;
  logic        clk = 0, reset = 1, MemRead = 0, MemWrite = 0;
  logic [31:0] Address = 0, Write_data = 0, Read_data;
  logic        irq;
  logic [7:0]  led, switch = 8'h5A;
  logic [11:0] digi;
  int checks = 0, passed = 0;

  peripheral_bus dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Address(Address), .Write_data(Write_data), .Read_data(Read_data),
    .irq(irq), .led(led), .switch(switch), .digi(digi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Model state: the architectural registers as the software sees them
  logic [31:0] m_th, m_tl, m_systick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_sw1, m_sw2;
  logic [11:0] m_digi;
  logic        valid = 0;

  function automatic logic m_hit(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'h1C && a % 4 == 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 0;
    case ((a - BASE) / 4)
      0: return m_th;
      1: return m_tl;
      2: return {29'd0, m_tcon};
      3: return {24'd0, m_led};
      4: return {24'd0, m_sw2};
      5: return {20'd0, m_digi};
      default: return m_systick;
    endcase
  endfunction

  logic [31:0] n_th, n_tl;
  logic [2:0]  n_tcon;
  logic        wrapping;
  always @(posedge clk) begin
    if (reset) begin
      m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0;
      m_systick = 0; m_sw1 = 0; m_sw2 = 0; valid = 1;
    end else begin
      wrapping = m_tcon[0] && m_tl == 32'hFFFF_FFFF;
      n_th = m_th;
      n_tcon = m_tcon;
      n_tl = !m_tcon[0] ? m_tl : wrapping ? m_th : m_tl + 1;
      if (MemWrite && m_hit(Address))
        case ((Address - BASE) / 4)
          0: n_th = Write_data;
          1: n_tl = Write_data;
          2: n_tcon = Write_data[2:0];
          3: m_led = Write_data[7:0];
          5: m_digi = Write_data[11:0];
          default: ;
        endcase
      if (wrapping && m_tcon[1]) n_tcon[2] = 1;
      m_th = n_th; m_tl = n_tl; m_tcon = n_tcon;
      m_systick = m_systick + 1;
      m_sw2 = m_sw1; m_sw1 = switch;
    end
  end

  always @(negedge clk) if (valid) begin
    chk("m_rdata", Read_data, MemRead ? m_read(Address) : 32'h0);
    chk("m_irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2]});
    chk("m_led", {24'd0, led}, {24'd0, m_led});
    chk("m_digi", {20'd0, digi}, {20'd0, m_digi});
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Address = a; Write_data = d; MemWrite = 1;
    tick();
    MemWrite = 0;
  endtask

  task automatic load_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    Address = a; MemRead = 1;
    #1 chk(name, Read_data, exp);
    MemRead = 0;
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    // 1: reset values
    load_chk("rst_systick", BASE + 32'h18, 32'h0);
    load_chk("rst_th", BASE + 32'h00, 32'h0);
    load_chk("rst_tl", BASE + 32'h04, 32'h0);
    load_chk("rst_tcon", BASE + 32'h08, 32'h0);
    load_chk("rst_led", BASE + 32'h0C, 32'h0);
    load_chk("rst_digi", BASE + 32'h14, 32'h0);
    load_chk("rst_sw0", BASE + 32'h10, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    tick();
    load_chk("sw_lag1", BASE + 32'h10, 32'h0);
    tick();
    load_chk("sw_lag2", BASE + 32'h10, 32'h5A);
    // 2: reload
    store(BASE + 32'h00, 32'hFFFF_FFFD);
    store(BASE + 32'h04, 32'hFFFF_FFFE);
    store(BASE + 32'h08, 32'h3);
    load_chk("tl_p0", BASE + 32'h04, 32'hFFFF_FFFE);
    tick();
    load_chk("tl_p1", BASE + 32'h04, 32'hFFFF_FFFF);
    chk("irq_p1", {31'd0, irq}, 32'h0);
    tick();
    load_chk("tl_p2", BASE + 32'h04, 32'hFFFF_FFFD);
    chk("irq_p2", {31'd0, irq}, 32'h1);
    tick();
    load_chk("tl_p3", BASE + 32'h04, 32'hFFFF_FFFE);
    // 3: clear racing an overflow, then a quiet clear
    tick();
    store(BASE + 32'h08, 32'h3);
    chk("irq_race", {31'd0, irq}, 32'h1);
    load_chk("tl_race", BASE + 32'h04, 32'hFFFF_FFFD);
    store(BASE + 32'h08, 32'h3);
    chk("irq_clr", {31'd0, irq}, 32'h0);
    // 4: LED / DIGI, store to read-only SWITCH
    store(BASE + 32'h0C, 32'hA5);
    chk("led", {24'd0, led}, 32'hA5);
    store(BASE + 32'h14, 32'hF3F);
    chk("digi", {20'd0, digi}, 32'hF3F);
    store(BASE + 32'h10, 32'hFFFF_FFFF);
    chk("led_ro", {24'd0, led}, 32'hA5);
    load_chk("sw_ro", BASE + 32'h10, 32'h5A);
    // 5: misaligned and out-of-window accesses
    load_chk("mis_rd", BASE + 32'h02, 32'h0);
    load_chk("oow_rd", BASE + 32'h20, 32'h0);
    store(BASE + 32'h02, 32'h1234_5678);
    store(BASE + 32'h20, 32'h1234_5678);
    store(BASE + 32'h2C, 32'h0000_0011);
    load_chk("th_keep", BASE + 32'h00, 32'hFFFF_FFFD);
    chk("led_keep", {24'd0, led}, 32'hA5);
    // 6: reset mid-count with irq pending
    store(BASE + 32'h08, 32'h7);
    chk("irq_set", {31'd0, irq}, 32'h1);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_irq2", {31'd0, irq}, 32'h0);
    load_chk("rst_systick2", BASE + 32'h18, 32'h0);
    load_chk("rst_tl2", BASE + 32'h04, 32'h0);
    tick(); tick();
    load_chk("systick_run", BASE + 32'h18, 32'h2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
